mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle multiply/divide sequencer for the P7 pipeline. It sits in the E stage and owns the HI/LO registers. It accepts mult/multu/div/divu/mthi/mtlo from the instruction in E, models the fixed unit latency with a countdown, and commits results to HI/LO at completion. It drives the `start` and `busy` signals that the hazard unit uses to stall MDU-related instructions in D, and it cancels issue when an exception/interrupt request flushes E.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input 1: exception/interrupt flush this cycle; suppresses any issue from E.
- `op` input 4: E-stage MDU op. 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 are treated as NONE.
- `a` input 32: rs operand (forwarded).
- `b` input 32: rt operand (forwarded).
- `start` output 1: combinational; `op`∈{1..4} & ~`busy` & ~`req`.
- `busy` output 1: registered; high while an operation is in flight.
- `hi` output 32: architectural HI.
- `lo` output 32: architectural LO.
- `rd` output 32: combinational read data; `hi` if op=MFHI, `lo` if op=MFLO, else 0.

## Operation
- State machine with two states.
  - **IDLE**: `busy`=0.
  - **RUN**: `busy`=1, counter `cnt` active.
- IDLE→RUN when `start`=1.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Latch the computed 64-bit result into pending registers `p_hi`/`p_lo`.
  - Latch a `commit` flag.
- RUN: `cnt` decrements each cycle.
  - When `cnt`=1: if `commit`=1, HI←`p_hi` and LO←`p_lo`; next state IDLE.
- Arithmetic:
  - MULT: signed 32×32→64; HI=upper, LO=lower.
  - MULTU: unsigned 32×32→64; HI=upper, LO=lower.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend. 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient in LO, remainder in HI.
  - Divide by zero (`b`=0, div or divu): the sequence still runs full DIV_CYCLES with `busy` high, but `commit`=0, so HI/LO are unchanged.
- MTHI/MTLO: when ~`busy` & ~`req`, HI←`a` (MTHI) or LO←`a` (MTLO) at the edge ending the cycle. No busy period.
- While `busy`=1, every op other than MFHI/MFLO is ignored; no restart, no mthi/mtlo write. The hazard unit guarantees none arrive. The ignore rule is a safety net and is verified.
- MFHI/MFLO are pure reads and never change state.
- `req`=1 blocks `start`, MTHI and MTLO in that cycle.
- An operation already in RUN is not affected by `req`; it runs to completion and commits.

## Timing
- Reset values: state IDLE, `busy`=0, `cnt`=0, `commit`=0, `hi`=0, `lo`=0, `p_hi`=`p_lo`=0.
- `start` and `rd` are 0 whenever `op`=NONE.
- Issue at cycle t (`start`=1 during t):
  - `busy`=1 in cycles t+1 … t+N, where N=MULT_CYCLES or DIV_CYCLES.
  - `hi`/`lo` show the new value from cycle t+N+1.
  - `busy`=0 in cycle t+N+1.
  - The earliest next `start` is cycle t+N+1.
- Back-to-back: a second issue in cycle t+N+1 is legal and gives `busy` continuously high apart from the one-cycle low at t+N+1.
- MTHI/MTLO in cycle t: the new HI/LO value is visible in cycle t+1.
- Reset asserted mid-RUN: the next cycle is IDLE with `busy`=0 and HI=LO=0. The pending result is discarded.
- Reset has priority over every other input.
- `req` and `start` conditions in the same cycle: no issue; `busy` stays 0.

## Test plan
- **Signed multiply.** `op`=MULT, `a`=0xFFFFFFFD, `b`=5 at t.
  - `busy`=1 for exactly t+1..t+5.
  - At t+6: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, `busy`=0.
- **Divides.**
  - DIVU 7/2: after 10 busy cycles, `lo`=3, `hi`=1.
  - DIV 0xFFFFFFF9/2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- **Divide by zero.** Preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV `a`=9, `b`=0.
  - `busy` high for 10 cycles.
  - Afterwards `hi`=0x11, `lo`=0x22.
- **Flush and reset.**
  - `req`=1 together with MULT: `start`=0, `busy` never rises, HI/LO unchanged.
  - MTHI with `req`=1: no write.
  - Reset asserted at the 3rd busy cycle of a DIV: next cycle `busy`=0, `hi`=`lo`=0.
- **Busy-time ignore.** During a MULT's busy window, present MTLO `a`=0xABCD and then DIVU.
  - Both are ignored; the final LO is the product's LO.
  - MFLO during busy returns the old LO on `rd`.
- **Back-to-back.** Issue MULT, then MULTU 0xFFFFFFFF×2 in the first cycle `busy`=0.
  - After the second op: `hi`=1, `lo`=0xFFFFFFFE.
  - `busy` is low for exactly one cycle between the two operations.

Source files
------------

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: E-stage MDU request/response bundle between pipeline and sequencer
interface mdu_sequencer_if;
  logic        req;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd;
  modport master (output req, op, a, b, input start, busy, hi, lo, rd);
  modport slave (input req, op, a, b, output start, busy, hi, lo, rd);
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide sequencer owning the HI/LO registers
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  mdu_sequencer_if.slave bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam logic [3:0] OP_MULT = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MTHI = 4'd5;
  localparam logic [3:0] OP_MTLO = 4'd6;
  localparam logic [3:0] OP_MFHI = 4'd7;
  localparam logic [3:0] OP_MFLO = 4'd8;
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic commit;
  logic [31:0] hi, lo, p_hi, p_lo;
  logic is_mul, is_div, div_zero, start, idle_ok;
  logic [63:0] prod_s, prod_u, res;
  logic [31:0] abs_a, abs_b, dvnd, dvsr, uq, ur, sq, sr;
  // Operand conditioning and the 64-bit result the unit would produce for the op in E
  always_comb begin
    is_mul = bus.op == OP_MULT || bus.op == OP_MULTU;
    is_div = bus.op == OP_DIV || bus.op == OP_DIVU;
    div_zero = is_div && bus.b == 32'd0;
    prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    prod_u = {32'd0, bus.a} * {32'd0, bus.b};
    abs_a = bus.a[31] ? -bus.a : bus.a;
    abs_b = bus.b[31] ? -bus.b : bus.b;
    dvnd = bus.op == OP_DIV ? abs_a : bus.a;
    dvsr = div_zero ? 32'd1 : bus.op == OP_DIV ? abs_b : bus.b;
    uq = dvnd / dvsr;
    ur = dvnd % dvsr;
    sq = bus.a[31] ^ bus.b[31] ? -uq : uq;
    sr = bus.a[31] ? -ur : ur;
    res = bus.op == OP_MULT ? prod_s : bus.op == OP_MULTU ? prod_u : bus.op == OP_DIV ? {sr, sq} : {ur, uq};
    idle_ok = state == IDLE && !bus.req;
    start = idle_ok && (is_mul || is_div);
  end
  // Issue, countdown and commit; MTHI/MTLO write only when idle and not flushed
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      commit <= 1'b0;
      hi <= '0;
      lo <= '0;
      p_hi <= '0;
      p_lo <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        cnt <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        p_hi <= res[63:32];
        p_lo <= res[31:0];
        commit <= !div_zero;
      end else if (idle_ok && bus.op == OP_MTHI) begin
        hi <= bus.a;
      end else if (idle_ok && bus.op == OP_MTLO) begin
        lo <= bus.a;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= IDLE;
        hi <= commit ? p_hi : hi;
        lo <= commit ? p_lo : lo;
      end
    end
  end
  assign bus.start = start;
  assign bus.busy = state == RUN;
  assign bus.hi = hi;
  assign bus.lo = lo;
  assign bus.rd = bus.op == OP_MFHI ? hi : bus.op == OP_MFLO ? lo : 32'd0;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench with a transaction-level HI/LO reference model
module tb_mdu_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  mdu_sequencer_if bus();
  mdu_sequencer dut (.clk(clk), .reset(reset), .bus(bus.slave));
  typedef struct {
    logic start;
    logic busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 0, m_lo = 0, q_hi = 0, q_lo = 0;
  bit q_commit = 0;
  int cyc_no = 0;
  int done_at = 0;
  // Compare one observed value against its expectation
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_no, act, exp);
    end
  endfunction
  // Architectural result of an arithmetic op computed with plain SV integer math
  function automatic void calc(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                               output logic [31:0] rh, output logic [31:0] rl, output bit ok);
    longint sp, sq, sr;
    longint unsigned up, uq, ur;
    ok = 1;
    rh = 0;
    rl = 0;
    if (o == 1) begin
      sp = longint'($signed(x)) * longint'($signed(y));
      {rh, rl} = sp[63:0];
    end else if (o == 2) begin
      up = longint'(x) * longint'(y);
      {rh, rl} = up[63:0];
    end else if (y == 0) begin
      ok = 0;
    end else if (o == 3) begin
      sq = longint'($signed(x)) / longint'($signed(y));
      sr = longint'($signed(x)) % longint'($signed(y));
      rl = sq[31:0];
      rh = sr[31:0];
    end else begin
      uq = longint'(x) / longint'(y);
      ur = longint'(x) % longint'(y);
      rl = uq[31:0];
      rh = ur[31:0];
    end
  endfunction
  // Drive one cycle, push the model's expectation, advance the model past the edge
  task automatic cyc(input bit r, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    bit bsy, ok;
    logic [31:0] rh, rl;
    if (q_commit && cyc_no >= done_at) begin
      m_hi = q_hi;
      m_lo = q_lo;
      q_commit = 0;
    end
    bus.req = r;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bsy = cyc_no < done_at;
    e.busy = bsy;
    e.start = o >= 1 && o <= 4 && !bsy && !r;
    e.hi = m_hi;
    e.lo = m_lo;
    e.rd = o == 7 ? m_hi : o == 8 ? m_lo : 32'd0;
    sb.push_back(e);
    if (e.start) begin
      calc(o, x, y, rh, rl, ok);
      done_at = cyc_no + 1 + (o <= 2 ? 5 : 10);
      q_commit = ok;
      q_hi = rh;
      q_lo = rl;
    end else if (!bsy && !r && o == 5) begin
      m_hi = x;
    end else if (!bsy && !r && o == 6) begin
      m_lo = x;
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, $urandom, $urandom);
  endtask
  task automatic do_reset();
    reset = 1;
    bus.req = 0;
    bus.op = 0;
    bus.a = 0;
    bus.b = 0;
    @(posedge clk);
    #1;
    reset = 0;
    cyc_no++;
    m_hi = 0;
    m_lo = 0;
    q_commit = 0;
    done_at = 0;
  endtask
  // Monitor: every cycle with an outstanding expectation is checked mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("start", 32'(bus.start), 32'(e.start));
      chk("busy", 32'(bus.busy), 32'(e.busy));
      chk("hi", bus.hi, e.hi);
      chk("lo", bus.lo, e.lo);
      chk("rd", bus.rd, e.rd);
    end
  end
  initial begin
    logic [3:0] o;
    logic [31:0] y;
    do_reset();
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_hi", bus.hi, 0);
    chk("reset_lo", bus.lo, 0);
    cyc(0, 1, 32'hFFFFFFFD, 5);
    idle(5);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFF1);
    chk("mult_busy", 32'(bus.busy), 0);
    cyc(0, 4, 7, 2);
    idle(10);
    chk("divu_lo", bus.lo, 3);
    chk("divu_hi", bus.hi, 1);
    cyc(0, 3, 32'hFFFFFFF9, 2);
    idle(10);
    chk("div_neg_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_neg_hi", bus.hi, 32'hFFFFFFFF);
    cyc(0, 3, 32'h80000000, 32'hFFFFFFFF);
    idle(10);
    chk("div_ovf_lo", bus.lo, 32'h80000000);
    chk("div_ovf_hi", bus.hi, 0);
    cyc(0, 5, 32'h11, 0);
    cyc(0, 6, 32'h22, 0);
    cyc(0, 3, 9, 0);
    idle(10);
    chk("dz_hi", bus.hi, 32'h11);
    chk("dz_lo", bus.lo, 32'h22);
    cyc(1, 1, 3, 4);
    cyc(1, 5, 32'hDEAD, 0);
    idle(2);
    chk("flush_busy", 32'(bus.busy), 0);
    chk("flush_hi", bus.hi, 32'h11);
    chk("flush_lo", bus.lo, 32'h22);
    cyc(0, 1, 3, 7);
    cyc(0, 6, 32'hABCD, 0);
    cyc(0, 4, 100, 3);
    cyc(0, 8, 0, 0);
    idle(3);
    chk("ignore_lo", bus.lo, 21);
    cyc(0, 1, 2, 3);
    idle(5);
    cyc(0, 2, 32'hFFFFFFFF, 2);
    idle(5);
    chk("b2b_hi", bus.hi, 1);
    chk("b2b_lo", bus.lo, 32'hFFFFFFFE);
    cyc(0, 3, 100, 7);
    idle(2);
    do_reset();
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    idle(12);
    chk("midrst_stay_hi", bus.hi, 0);
    for (int i = 0; i < 3000; i++) begin
      o = 4'($urandom_range(0, 15));
      y = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 9)) : $urandom;
      cyc($urandom_range(0, 9) == 0, o, $urandom, y);
    end
    idle(12);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
